// File: rtl/seq_array_multiplier_if.sv
// Handshake bundle for seq_array_multiplier: operand input channel, product
// output channel and the busy status flag.
interface seq_array_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_array_multiplier.sv
// Sequential radix-2 shift-add multiplier, signed or unsigned per transaction.
// Optional early termination on an exhausted multiplier: SEQ_ARRAY_MULTIPLIER_EARLY_TERM_EN.
module seq_array_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_array_multiplier_if.slave  bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Widen an operand to product width, replicating the sign bit in signed mode.
    function automatic logic [PW-1:0] extend_operand(input logic [WIDTH-1:0] v, input logic sgn);
        return {{WIDTH{sgn & v[WIDTH-1]}}, v};
    endfunction

    logic [1:0]       state_r;
    logic [PW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [PW-1:0]    acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             signed_r;
    logic [PW-1:0]    product_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [PW-1:0]    addend_s;
    logic [PW-1:0]    acc_next_s;
    logic [WIDTH-1:0] mplier_next_s;
    logic             last_bit_s;
    logic             finish_s;
    logic             accept_s;
    logic             release_s;

    assign accept_s  = bus.in_valid & in_ready_r;
    assign release_s = out_valid_r & bus.out_ready;

    // One shift-add step; the sign bit of a signed multiplier carries negative weight.
    always_comb begin
        addend_s      = {PW{1'b0}};
        acc_next_s    = acc_r;
        mplier_next_s = {1'b0, mplier_r[WIDTH-1:1]};
        last_bit_s    = (cnt_r == LAST_BIT);
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {PW{1'b0}};
        end
        if (last_bit_s && signed_r) begin
            acc_next_s = acc_r - addend_s;
        end else begin
            acc_next_s = acc_r + addend_s;
        end
    end

`ifdef SEQ_ARRAY_MULTIPLIER_EARLY_TERM_EN
    // Remaining zero multiplier bits add nothing, so stop as soon as none are left.
    assign finish_s = last_bit_s | (mplier_next_s == {WIDTH{1'b0}});
`else
    assign finish_s = last_bit_s;
`endif

    // Control FSM and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r    <= ST_CALC;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (finish_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (release_s) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // Operand latch, accumulate/shift datapath and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {PW{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            signed_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mcand_r  <= extend_operand(bus.a, bus.signed_mode);
                        mplier_r <= bus.b;
                        signed_r <= bus.signed_mode;
                        acc_r    <= {PW{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                ST_CALC: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= {mcand_r[PW-2:0], 1'b0};
                    mplier_r <= mplier_next_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                end
                ST_DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= {PW{1'b0}};
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Product register: only ever loaded with a completed result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_r <= {PW{1'b0}};
        end else if ((state_r == ST_CALC) && finish_s) begin
            product_r <= acc_next_s;
        end else begin
            product_r <= product_r;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.product   = product_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed self-checking bench for seq_array_multiplier at WIDTH=4.
module tb_seq_array_multiplier;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

`ifdef SEQ_ARRAY_MULTIPLIER_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    seq_array_multiplier_if #(.WIDTH(4)) bus ();

    seq_array_multiplier #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total_cnt++;
        if (act !== exp_v) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        else pass_cnt++;
    endtask

    task automatic start_op(input logic [3:0] aa, input logic [3:0] bb, input logic sm);
        bus.a = aa;
        bus.b = bb;
        bus.signed_mode = sm;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        while (edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (bus.out_valid === 1'b1) break;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.product !== 8'h00) $display("FAIL reset_product: got %h expected 00", bus.product); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_max();
        int e;
        start_op(4'hF, 4'hF, 1'b0);
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL umax_in_ready_calc: got %b expected 0", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL umax_busy_calc: got %b expected 1", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL umax_out_valid_calc: got %b expected 0", bus.out_valid); else pass_cnt++;
        wait_out(e);
        total_cnt++; if (e !== 4) $display("FAIL umax_latency: got %0d expected 4", e); else pass_cnt++;
        total_cnt++; if (bus.product !== 8'hE1) $display("FAIL umax_product: got %h expected e1", bus.product); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL umax_in_ready_done: got %b expected 0", bus.in_ready); else pass_cnt++;
        drain();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL umax_out_valid_idle: got %b expected 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL umax_in_ready_idle: got %b expected 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL umax_busy_idle: got %b expected 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_signed();
        int e;
        start_op(4'h8, 4'h7, 1'b1);
        wait_out(e);
        total_cnt++; if (e !== (EARLY ? 3 : 4)) $display("FAIL smix_latency: got %0d expected %0d", e, (EARLY ? 3 : 4)); else pass_cnt++;
        total_cnt++; if (bus.product !== 8'hC8) $display("FAIL smix_product: got %h expected c8", bus.product); else pass_cnt++;
        drain();
        start_op(4'h8, 4'h8, 1'b1);
        wait_out(e);
        total_cnt++; if (e !== 4) $display("FAIL scorner_latency: got %0d expected 4", e); else pass_cnt++;
        total_cnt++; if (bus.product !== 8'h40) $display("FAIL scorner_product: got %h expected 40", bus.product); else pass_cnt++;
        drain();
    endtask

    task automatic test_backpressure();
        int e;
        start_op(4'h3, 4'h5, 1'b0);
        wait_out(e);
        total_cnt++; if (e !== (EARLY ? 3 : 4)) $display("FAIL bp_latency: got %0d expected %0d", e, (EARLY ? 3 : 4)); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (bus.out_valid !== 1'b1 || bus.product !== 8'h0F)
                $display("FAIL bp_hold_%0d: got valid=%b product=%h expected valid=1 product=0f", i, bus.out_valid, bus.product);
            else pass_cnt++;
        end
        drain();
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_in_ready_after: got %b expected 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bp_out_valid_after: got %b expected 0", bus.out_valid); else pass_cnt++;
    endtask

    task automatic test_ignored_input();
        int e;
        int seen;
        start_op(4'h3, 4'h3, 1'b0);
        bus.a = 4'h2;
        bus.b = 4'h2;
        bus.in_valid = 1'b1;
        wait_out(e);
        bus.in_valid = 1'b0;
        total_cnt++; if (e !== (EARLY ? 2 : 4)) $display("FAIL ign_latency: got %0d expected %0d", e, (EARLY ? 2 : 4)); else pass_cnt++;
        total_cnt++; if (bus.product !== 8'h09) $display("FAIL ign_product: got %h expected 09", bus.product); else pass_cnt++;
        drain();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        total_cnt++; if (seen !== 0) $display("FAIL ign_second_result: got %0d extra out_valid cycles expected 0", seen); else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        int e;
        start_op(4'h5, 4'h5, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %b expected 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.product !== 8'h00) $display("FAIL rmid_product: got %h expected 00", bus.product); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b expected 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", bus.busy); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        start_op(4'h6, 4'h7, 1'b0);
        wait_out(e);
        total_cnt++; if (e !== (EARLY ? 3 : 4)) $display("FAIL rmid_next_latency: got %0d expected %0d", e, (EARLY ? 3 : 4)); else pass_cnt++;
        total_cnt++; if (bus.product !== 8'h2A) $display("FAIL rmid_next_product: got %h expected 2a", bus.product); else pass_cnt++;
        drain();
    endtask

    task automatic test_early_term();
        int e;
        start_op(4'h9, 4'h1, 1'b0);
        wait_out(e);
        total_cnt++; if (e !== (EARLY ? 1 : 4)) $display("FAIL et_b1_latency: got %0d expected %0d", e, (EARLY ? 1 : 4)); else pass_cnt++;
        total_cnt++; if (bus.product !== 8'h09) $display("FAIL et_b1_product: got %h expected 09", bus.product); else pass_cnt++;
        drain();
        start_op(4'h5, 4'h0, 1'b0);
        wait_out(e);
        total_cnt++; if (e !== (EARLY ? 1 : 4)) $display("FAIL et_b0_latency: got %0d expected %0d", e, (EARLY ? 1 : 4)); else pass_cnt++;
        total_cnt++; if (bus.product !== 8'h00) $display("FAIL et_b0_product: got %h expected 00", bus.product); else pass_cnt++;
        drain();
        start_op(4'h3, 4'hF, 1'b1);
        wait_out(e);
        total_cnt++; if (e !== 4) $display("FAIL et_negb_latency: got %0d expected 4", e); else pass_cnt++;
        total_cnt++; if (bus.product !== 8'hFD) $display("FAIL et_negb_product: got %h expected fd", bus.product); else pass_cnt++;
        drain();
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        bus.in_valid = 1'b0;
        bus.a = 4'h0;
        bus.b = 4'h0;
        bus.signed_mode = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_backpressure();
        test_ignored_input();
        test_reset_midop();
        test_early_term();
        chk("final_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
